// File: rtl/cvxif_result_buffer.sv
// cvxif_result_buffer: in-order coprocessor result FIFO with kill support; optional macro CVXIF_RESULT_BUFFER_BYPASS_EN enables empty-FIFO bypass
module cvxif_result_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ID_W  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ID_W-1:0]         in_id_i,
    input  logic [XLEN-1:0]         in_data_i,
    input  logic [4:0]              in_rd_i,
    input  logic                    in_we_i,
    input  logic                    commit_valid_i,
    input  logic [ID_W-1:0]         commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [ID_W-1:0]         result_id_o,
    output logic [XLEN-1:0]         result_data_o,
    output logic [4:0]              result_rd_o,
    output logic                    result_we_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [ID_W-1:0] id_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [4:0]      rd_q   [DEPTH];
    logic [DEPTH-1:0] we_q, killed_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic empty, kill, in_kill, head_live, byp, push, pop;
    assign empty      = count == '0;
    assign kill       = commit_valid_i & commit_kill_i;
    assign in_kill    = kill & (commit_id_i == in_id_i);
    assign head_live  = !empty & !killed_q[rd_ptr];
    assign in_ready_o = rst_i | (count < FULL);
    assign result_valid_o = !rst_i & (head_live | byp);
    assign pop  = !rst_i & !empty & (killed_q[rd_ptr] | result_ready_i);
    assign push = !rst_i & in_valid_i & (count < FULL) & !(byp & result_ready_i);
    assign count_o = count;
`ifdef CVXIF_RESULT_BUFFER_BYPASS_EN
    assign byp           = !rst_i & empty & in_valid_i & !in_kill;
    assign result_id_o   = byp ? in_id_i   : id_q[rd_ptr];
    assign result_data_o = byp ? in_data_i : data_q[rd_ptr];
    assign result_rd_o   = byp ? in_rd_i   : rd_q[rd_ptr];
    assign result_we_o   = byp ? in_we_i   : we_q[rd_ptr];
`else
    assign byp           = 1'b0;
    assign result_id_o   = id_q[rd_ptr];
    assign result_data_o = data_q[rd_ptr];
    assign result_rd_o   = rd_q[rd_ptr];
    assign result_we_o   = we_q[rd_ptr];
`endif
    // pointers, occupancy and kill flags; a push overrides any stale kill on its slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            killed_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && id_q[i] == commit_id_i) killed_q[i] <= 1'b1;
            if (push) begin
                killed_q[wr_ptr] <= in_kill;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // payload storage, written only on accepted pushes and never reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr]   <= in_id_i;
            data_q[wr_ptr] <= in_data_i;
            rd_q[wr_ptr]   <= in_rd_i;
            we_q[wr_ptr]   <= in_we_i;
        end
    end
endmodule

// File: tb/tb_cvxif_result_buffer.sv
// tb_cvxif_result_buffer: randomized and directed check of cvxif_result_buffer against a queue model
module tb_cvxif_result_buffer;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1;
    logic iv = 0, we = 0, cv = 0, ck = 0, rr = 0;
    logic [3:0] iid = 0, cid = 0;
    logic [63:0] d = 0;
    logic [4:0] rd = 0;
    logic in_ready, r_valid, r_we;
    logic [3:0] r_id;
    logic [63:0] r_data;
    logic [4:0] r_rd;
    logic [2:0] cnt;
    int tests = 0, fails = 0;
    bit known = 0;
`ifdef CVXIF_RESULT_BUFFER_BYPASS_EN
    localparam bit BYP = 1;
`else
    localparam bit BYP = 0;
`endif
    typedef struct {logic [3:0] id; logic [63:0] data; logic [4:0] rd; logic we; logic k;} ent_t;
    ent_t q[$];
    ent_t seen[$];

    always #5 clk = ~clk;

    cvxif_result_buffer #(.DEPTH(DEPTH), .XLEN(64), .ID_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(in_ready),
        .in_id_i(iid), .in_data_i(d), .in_rd_i(rd), .in_we_i(we),
        .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
        .result_valid_o(r_valid), .result_ready_i(rr),
        .result_id_o(r_id), .result_data_o(r_data), .result_rd_o(r_rd), .result_we_o(r_we),
        .count_o(cnt)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // one clock: compare DUT against model at negedge, then advance model at posedge
    task automatic tick();
        bit in_k, byp, ex_valid, pop, push;
        ent_t h;
        @(negedge clk);
        in_k = cv && ck && cid == iid;
        byp = BYP && !rst && q.size() == 0 && iv && !in_k;
        ex_valid = !rst && ((q.size() > 0 && !q[0].k) || byp);
        h = byp ? '{iid, d, rd, we, 1'b0} : (q.size() > 0 ? q[0] : '{4'h0, 64'h0, 5'h0, 1'b0, 1'b0});
        chk("in_ready", in_ready, rst || q.size() < DEPTH);
        chk("result_valid", r_valid, ex_valid);
        if (known && !rst) chk("count", cnt, q.size());
        if (ex_valid) begin
            chk("result_id", r_id, h.id);
            chk("result_data", r_data, h.data);
            chk("result_rd", r_rd, h.rd);
            chk("result_we", r_we, h.we);
            if (rr) seen.push_back('{r_id, r_data, r_rd, r_we, 1'b0});
        end
        pop = !rst && q.size() > 0 && (q[0].k || rr);
        push = !rst && iv && q.size() < DEPTH && !(byp && rr);
        @(posedge clk);
        if (rst) begin
            q.delete();
            known = 1;
        end else begin
            if (cv && ck) foreach (q[i]) if (q[i].id == cid) q[i].k = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{iid, d, rd, we, in_k});
        end
        #1;
    endtask

    task automatic idle();
        iv = 0; cv = 0; ck = 0; rst = 0;
    endtask

    task automatic push_id(input logic [3:0] id);
        iv = 1; iid = id; d = 64'h100 + 64'(id); rd = 5'(id); we = id[0];
    endtask

    task automatic reset_seq();
        idle(); rst = 1; tick(); rst = 0; seen.delete();
    endtask

    initial begin
        rst = 1; tick(); tick(); idle(); #1;
        chk("reset_count", cnt, 0);
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", r_valid, 0);

        // in-order delivery with ready held high
        rr = 1;
        for (int i = 1; i <= 3; i++) begin push_id(4'(i)); tick(); end
        idle();
        repeat (3) tick();
        chk("inorder_n", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            chk("inorder_id", seen[i].id, i + 1);
            chk("inorder_data", seen[i].data, 64'h101 + 64'(i));
        end
        chk("inorder_count", cnt, 0);

        // fill to full with ready low, fifth accepted the cycle after the first pop
        reset_seq(); rr = 0;
        for (int i = 0; i < 4; i++) begin push_id(4'(i)); tick(); end
        push_id(4); #1;
        chk("full_count", cnt, 4);
        chk("full_ready", in_ready, 0);
        rr = 1; tick();
        chk("after_pop_count", cnt, 3);
        chk("after_pop_ready", in_ready, 1);
        rr = 0; tick();
        chk("fifth_count", cnt, 4);
        idle(); rr = 1;
        repeat (5) tick();
        chk("full_n", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("full_id", seen[i].id, i);

        // kill a middle entry
        reset_seq(); rr = 0;
        for (int i = 2; i <= 4; i++) begin push_id(4'(i)); tick(); end
        idle(); cv = 1; ck = 1; cid = 3; tick();
        idle(); rr = 1;
        tick(); tick();
        chk("kill_drop_count", cnt, 1);
        tick();
        chk("kill_n", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("kill_first", seen[0].id, 2);
            chk("kill_second", seen[1].id, 4);
        end

        // push and kill of the same id in one cycle
        reset_seq(); rr = 1;
        push_id(7); cv = 1; ck = 1; cid = 7; tick();
        idle(); #1;
        chk("samekill_count1", cnt, 1);
        chk("samekill_valid", r_valid, 0);
        tick();
        chk("samekill_count0", cnt, 0);
        chk("samekill_seen", seen.size(), 0);

        // reset mid-operation
        reset_seq(); rr = 0;
        for (int i = 1; i <= 3; i++) begin push_id(4'(i)); tick(); end
        idle(); #1;
        chk("mid_valid_pre", r_valid, 1);
        chk("mid_count_pre", cnt, 3);
        rst = 1; tick(); rst = 0; #1;
        chk("mid_count", cnt, 0);
        chk("mid_valid", r_valid, 0);
        chk("mid_ready", in_ready, 1);

        // latency from push to result_valid
        reset_seq(); rr = 1;
        push_id(1); #1;
        chk("lat_same_cycle", r_valid, BYP);
        tick(); idle(); #1;
        chk("lat_count", cnt, BYP ? 0 : 1);
        chk("lat_next_cycle", r_valid, !BYP);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 100) == 0;
            iv = ($urandom % 10) < 6;
            iid = 4'($urandom % 4);
            d = {$urandom, $urandom};
            rd = 5'($urandom);
            we = 1'($urandom);
            cv = ($urandom % 10) < 3;
            ck = 1'($urandom);
            cid = 4'($urandom % 4);
            rr = 1'($urandom);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cvxif_result_buffer.md
CVXIF_RESULT_BUFFER -- requirements
Module: cvxif_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter XLEN, default 64, result data width.
REQ-003 SHALL have parameter ID_W, default 4, instruction id width.
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid_i in 1 / in_ready_o out 1: coprocessor result push handshake.
REQ-007 SHALL have ports in_id_i in ID_W, in_data_i in XLEN, in_rd_i in 5, in_we_i in 1: pushed result payload.
REQ-008 SHALL have ports commit_valid_i in 1, commit_id_i in ID_W, commit_kill_i in 1: core commit/kill of an offloaded instruction.
REQ-009 SHALL have ports result_valid_o out 1 / result_ready_i in 1: result handshake toward core.
REQ-010 SHALL have ports result_id_o out ID_W, result_data_o out XLEN, result_rd_o out 5, result_we_o out 1: head payload.
REQ-011 SHALL have port count_o out $clog2(DEPTH)+1: stored entries, killed ones included.

Function
REQ-012 SHALL store pushed results in order in a circular FIFO of DEPTH entries, each entry {id, data, rd, we, killed}.
REQ-013 SHALL drive in_ready_o = (count_o < DEPTH), independent of result_ready_i.
REQ-014 SHALL push when in_valid_i & in_ready_o; payload ignored otherwise.
REQ-015 SHALL mark every stored entry with id == commit_id_i as killed when commit_valid_i & commit_kill_i, effective next cycle.
REQ-016 SHALL set killed on an entry pushed in the same cycle as a matching kill.
REQ-017 SHALL ignore commit_valid_i with commit_kill_i = 0; it changes no state.
REQ-018 SHALL drive result_valid_o = 1 only when FIFO non-empty and head not killed; payload outputs show head entry.
REQ-019 SHALL pop head when result_valid_o & result_ready_i.
REQ-020 SHALL pop a killed head without asserting result_valid_o, one entry per cycle, regardless of result_ready_i.
REQ-021 SHALL hold result payload stable while result_valid_o & !result_ready_i; sole exception: head killed per REQ-015, then result_valid_o drops next cycle.
REQ-022 SHALL handle simultaneous push and pop: count unchanged, both take effect, including at count == DEPTH-1 and at count == 1.
REQ-023 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-024 SHALL have minimum push-to-result_valid_o latency of 1 cycle when macro of REQ-029 absent.

Reset
REQ-025 SHALL, with rst_i high at a clock edge, clear pointers, count_o = 0, all killed flags = 0.
REQ-026 SHALL hold result_valid_o = 0, in_ready_o = 1 during and first cycle after reset; payload outputs don't-care when result_valid_o = 0.
REQ-027 SHALL discard in-flight entries and ignore push/commit inputs on any cycle rst_i is high, including mid-operation.
REQ-028 SHALL take no action on the reset value of payload storage (no storage reset required).

Configuration
REQ-029 SHALL, with CVXIF_RESULT_BUFFER_BYPASS_EN defined, when FIFO empty, in_valid_i = 1 and no same-cycle kill of in_id_i: assert result_valid_o combinationally with input payload; if result_ready_i = 1 the result is not stored.
REQ-030 SHALL, without CVXIF_RESULT_BUFFER_BYPASS_EN, never drive result_* from in_* combinationally; latency per REQ-024.

Verification
REQ-031 Push ids 1,2,3 back-to-back, result_ready_i = 1 -> results id 1,2,3 in order, data intact, count_o returns to 0.
REQ-032 result_ready_i = 0, push 5 results at DEPTH=4 -> in_ready_o = 0 after 4th, count_o = 4; 5th accepted one cycle after first pop.
REQ-033 Store ids 2,3,4; kill id 3 -> core sees id 2 then id 4 only; killed id 3 dropped in one cycle.
REQ-034 Push id 7 same cycle as kill id 7 -> id 7 never presented, count_o goes 1 then 0.
REQ-035 Assert rst_i with 3 entries stored and result_valid_o = 1 -> next cycle count_o = 0, result_valid_o = 0, in_ready_o = 1.
REQ-036 With BYPASS_EN, empty FIFO, push id 1 with result_ready_i = 1 -> result_valid_o same cycle, count_o stays 0; without macro -> result_valid_o one cycle later.
